sprite_motion_ctrl: RTL and testbench

SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

---
 rtl/sprite_motion_ctrl.sv | 151 +++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion sequencer: on each VS rising edge it walks the sprite table and bounces each sprite.
// Optional build macro SPRITE_PAUSE_EN adds a Pause input that suppresses starting a new frame update.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | waiting for a VS rising edge
// ST_UPDATE | moving sprite idx this cycle, one sprite per cycle
// ST_DONE   | single-cycle FrameDone pulse, then back to idle
module sprite_motion_ctrl #(
    parameter int NSPR     = 4,
    parameter int SPR_SIZE = 32,
    parameter int H_ACT    = 640,
    parameter int V_ACT    = 480
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                VS,
`ifdef SPRITE_PAUSE_EN
    input  logic                Pause,
`endif
    input  logic                CfgWe,
    input  logic [2:0]          CfgIdx,
    input  logic [9:0]          CfgX,
    input  logic [9:0]          CfgY,
    input  logic                CfgXd,
    input  logic                CfgYd,
    output logic [10*NSPR-1:0]  XPos,
    output logic [10*NSPR-1:0]  YPos,
    output logic                Busy,
    output logic                FrameDone
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [9:0] X_LIM    = 10'(H_ACT - 1 - SPR_SIZE);
    localparam logic [9:0] Y_LIM    = 10'(V_ACT - 1 - SPR_SIZE);
    localparam logic [2:0] IDX_LAST = 3'(NSPR - 1);

    logic [1:0]      state;
    logic [2:0]      idx;
    logic            vs_q;
    logic            upd;
    logic            pause_w;

    logic [9:0]      x_r [NSPR];
    logic [9:0]      y_r [NSPR];
    logic [NSPR-1:0] xd_r;
    logic [NSPR-1:0] yd_r;

    logic [9:0]      cur_x, cur_y, nxt_x, nxt_y;
    logic            cur_xd, cur_yd, nxt_xd, nxt_yd;

`ifdef SPRITE_PAUSE_EN
    assign pause_w = Pause;
`else
    assign pause_w = 1'b0;
`endif

    assign upd = VS & ~vs_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vs_q  <= 1'b0;
            state <= ST_IDLE;
            idx   <= 3'd0;
        end else begin
            vs_q <= VS;
            case (state)
                ST_IDLE: begin
                    idx <= 3'd0;
                    if (upd && !pause_w)
                        state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (idx == IDX_LAST) begin
                        state <= ST_DONE;
                        idx   <= 3'd0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    idx   <= 3'd0;
                end
            endcase
        end
    end

    // Single shared incrementer/decrementer: select the current sprite, compute its next position.
    always_comb begin
        cur_x  = '0;
        cur_y  = '0;
        cur_xd = 1'b0;
        cur_yd = 1'b0;
        for (int i = 0; i < NSPR; i++) begin
            if (idx == 3'(i)) begin
                cur_x  = x_r[i];
                cur_y  = y_r[i];
                cur_xd = xd_r[i];
                cur_yd = yd_r[i];
            end
        end
        nxt_x  = cur_xd ? cur_x + 10'd1 : cur_x - 10'd1;
        nxt_y  = cur_yd ? cur_y + 10'd1 : cur_y - 10'd1;
        nxt_xd = cur_xd ? (cur_x < X_LIM) : (cur_x <= 10'd1);
        nxt_yd = cur_yd ? (cur_y < Y_LIM) : (cur_y <= 10'd1);
    end

    // A config write to the sprite being moved this cycle takes priority over the motion step.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NSPR; i++) begin
                x_r[i]  <= 10'(32 + 64 * i);
                y_r[i]  <= 10'(32 + 48 * i);
                xd_r[i] <= 1'b1;
                yd_r[i] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < NSPR; i++) begin
                if (CfgWe && CfgIdx == 3'(i)) begin
                    x_r[i]  <= CfgX;
                    y_r[i]  <= CfgY;
                    xd_r[i] <= CfgXd;
                    yd_r[i] <= CfgYd;
                end else if (state == ST_UPDATE && idx == 3'(i)) begin
                    x_r[i]  <= nxt_x;
                    y_r[i]  <= nxt_y;
                    xd_r[i] <= nxt_xd;
                    yd_r[i] <= nxt_yd;
                end
            end
        end
    end

    always_comb begin
        XPos = '0;
        YPos = '0;
        for (int i = 0; i < NSPR; i++) begin
            XPos[10*i +: 10] = x_r[i];
            YPos[10*i +: 10] = y_r[i];
        end
    end

    assign Busy      = (state == ST_UPDATE);
    assign FrameDone = (state == ST_DONE);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: directed frames plus randomized config writes against a table model.
// Compiles with or without SPRITE_PAUSE_EN; the pause check only runs when the macro is defined.
module tb_sprite_motion_ctrl;

    localparam int NSPR = 4;
    localparam int SPR_SIZE = 32;
    localparam int H_ACT = 640;
    localparam int V_ACT = 480;

    logic CLK = 1'b0;
    logic RST, VS, CfgWe, CfgXd, CfgYd;
    logic [2:0] CfgIdx;
    logic [9:0] CfgX, CfgY;
    logic [10*NSPR-1:0] XPos, YPos;
    logic Busy, FrameDone;
`ifdef SPRITE_PAUSE_EN
    logic Pause = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    int mx [NSPR];
    int my [NSPR];
    bit mxd [NSPR];
    bit myd [NSPR];

    sprite_motion_ctrl #(.NSPR(NSPR), .SPR_SIZE(SPR_SIZE), .H_ACT(H_ACT), .V_ACT(V_ACT)) dut (
        .CLK(CLK), .RST(RST), .VS(VS),
`ifdef SPRITE_PAUSE_EN
        .Pause(Pause),
`endif
        .CfgWe(CfgWe), .CfgIdx(CfgIdx), .CfgX(CfgX), .CfgY(CfgY), .CfgXd(CfgXd), .CfgYd(CfgYd),
        .XPos(XPos), .YPos(YPos), .Busy(Busy), .FrameDone(FrameDone)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSPR; i++) begin
            mx[i] = 32 + 64 * i;
            my[i] = 32 + 48 * i;
            mxd[i] = 1;
            myd[i] = 1;
        end
    endtask

    // Bounce rule on one axis: step toward the direction, turn around at the limits (pre-step value).
    task automatic axis_step(inout int p, inout bit d, input int act);
        int old;
        old = p;
        if (d) begin
            p = (old + 1) % 1024;
            if (old >= act - 1 - SPR_SIZE) d = 0;
        end else begin
            p = (old + 1023) % 1024;
            if (old <= 1) d = 1;
        end
    endtask

    task automatic model_move(input int i);
        int p; bit d;
        p = mx[i]; d = mxd[i]; axis_step(p, d, H_ACT); mx[i] = p; mxd[i] = d;
        p = my[i]; d = myd[i]; axis_step(p, d, V_ACT); my[i] = p; myd[i] = d;
    endtask

    task automatic check_pos(input string tag);
        for (int i = 0; i < NSPR; i++) begin
            chk($sformatf("%s x%0d", tag, i), 32'(XPos[10*i +: 10]), 32'(mx[i]));
            chk($sformatf("%s y%0d", tag, i), 32'(YPos[10*i +: 10]), 32'(my[i]));
        end
    endtask

    task automatic cfg_idle(input logic [2:0] widx, input int x, input int y, input bit xd, input bit yd);
        @(negedge CLK);
        CfgWe = 1; CfgIdx = widx; CfgX = 10'(x); CfgY = 10'(y); CfgXd = xd; CfgYd = yd;
        @(posedge CLK);
        if (widx < NSPR) begin
            mx[widx] = x; my[widx] = y; mxd[widx] = xd; myd[widx] = yd;
        end
        #1;
        CfgWe = 0;
        check_pos("cfg_idle");
        chk("cfg_idle busy", 32'(Busy), 0);
    endtask

    // One frame; optional config write landing on edge t+1+wr_step, optional second VS rise mid-update.
    task automatic frame(input int wr_step, input logic [2:0] widx, input int x, input int y,
                         input bit xd, input bit yd, input bit retrig);
        @(negedge CLK);
        VS = 1;
        @(posedge CLK);
        #1;
        chk("start busy", 32'(Busy), 1);
        chk("start done", 32'(FrameDone), 0);
        check_pos("start");
        for (int k = 0; k < NSPR; k++) begin
            @(negedge CLK);
            if (retrig && k == 0) VS = 0;
            if (retrig && k == 1) VS = 1;
            if (k == wr_step) begin
                CfgWe = 1; CfgIdx = widx; CfgX = 10'(x); CfgY = 10'(y); CfgXd = xd; CfgYd = yd;
            end
            @(posedge CLK);
            model_move(k);
            if (k == wr_step && widx < NSPR) begin
                mx[widx] = x; my[widx] = y; mxd[widx] = xd; myd[widx] = yd;
            end
            #1;
            CfgWe = 0;
            check_pos($sformatf("step%0d", k));
            chk($sformatf("busy%0d", k), 32'(Busy), (k < NSPR - 1) ? 1 : 0);
            chk($sformatf("done%0d", k), 32'(FrameDone), (k == NSPR - 1) ? 1 : 0);
        end
        @(negedge CLK);
        VS = 0;
        @(posedge CLK);
        #1;
        chk("end busy", 32'(Busy), 0);
        chk("end done", 32'(FrameDone), 0);
        check_pos("end");
    endtask

    initial begin
        RST = 1; VS = 0; CfgWe = 0; CfgIdx = 0; CfgX = 0; CfgY = 0; CfgXd = 0; CfgYd = 0;
        model_reset();
        #22;
        check_pos("reset");
        chk("reset busy", 32'(Busy), 0);
        chk("reset done", 32'(FrameDone), 0);
        @(negedge CLK);
        RST = 0;
        repeat (2) @(posedge CLK);

        // First frame from reset values
        frame(-1, 0, 0, 0, 0, 0, 0);
        chk("f1 s0x", 32'(XPos[9:0]), 33);
        chk("f1 s0y", 32'(YPos[9:0]), 33);
        chk("f1 s3x", 32'(XPos[39:30]), 225);
        chk("f1 s3y", 32'(YPos[39:30]), 177);

        // Right-edge bounce on sprite 1
        cfg_idle(3'd1, 607, 100, 1, 1);
        frame(-1, 0, 0, 0, 0, 0, 0);
        chk("bounce x1 a", 32'(XPos[19:10]), 608);
        frame(-1, 0, 0, 0, 0, 0, 0);
        chk("bounce x1 b", 32'(XPos[19:10]), 607);

        // Top-edge bounce on sprite 2
        cfg_idle(3'd2, 300, 1, 1, 0);
        frame(-1, 0, 0, 0, 0, 0, 0);
        chk("bounce y2 a", 32'(YPos[29:20]), 0);
        frame(-1, 0, 0, 0, 0, 0, 0);
        chk("bounce y2 b", 32'(YPos[29:20]), 1);

        // Out-of-range position reverses on next update
        cfg_idle(3'd3, 1000, 470, 1, 1);
        frame(-1, 0, 0, 0, 0, 0, 0);
        chk("oor x3 a", 32'(XPos[39:30]), 1001);
        frame(-1, 0, 0, 0, 0, 0, 0);
        chk("oor x3 b", 32'(XPos[39:30]), 1000);

        // Write collides with sprite 1's update edge; also a second VS rise mid-update
        cfg_idle(3'd1, 200, 200, 1, 1);
        frame(1, 3'd1, 100, 150, 1, 1, 1);
        chk("collide x1", 32'(XPos[19:10]), 100);
        chk("collide y1", 32'(YPos[19:10]), 150);

        // Reset in the middle of an update sequence
        @(negedge CLK);
        VS = 1;
        @(posedge CLK);
        @(posedge CLK);
        model_move(0);
        @(posedge CLK);
        model_move(1);
        #1;
        check_pos("pre-rst");
        #2;
        RST = 1;
        #1;
        model_reset();
        check_pos("async rst");
        chk("async rst busy", 32'(Busy), 0);
        chk("async rst done", 32'(FrameDone), 0);
        @(negedge CLK);
        RST = 0;
        VS = 0;
        @(posedge CLK);
        #1;
        chk("post rst busy", 32'(Busy), 0);
        check_pos("post rst");

`ifdef SPRITE_PAUSE_EN
        @(negedge CLK);
        Pause = 1;
        VS = 1;
        for (int k = 0; k < NSPR + 2; k++) begin
            @(posedge CLK);
            #1;
            chk("pause busy", 32'(Busy), 0);
            chk("pause done", 32'(FrameDone), 0);
        end
        check_pos("pause");
        @(negedge CLK);
        VS = 0;
        Pause = 0;
`endif

        // Randomized frames with random config writes
        for (int f = 0; f < 30; f++) begin
            int ws;
            ws = $urandom_range(0, NSPR + 1);
            frame(ws, 3'($urandom_range(0, 7)), $urandom_range(2, 1020), $urandom_range(2, 1020),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0)
                cfg_idle(3'($urandom_range(0, 7)), $urandom_range(2, 1020), $urandom_range(2, 1020),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
